point_out_serializer: RTL and testbench
=======================================

Name: point_out_serializer

Overview:
- Downstream of the projective-to-affine reduction stage: captures the affine point (x, y) on that stage's one-cycle finished pulse.
- Forces each coordinate into canonical range [0, p), p = 2^255-19.
- Streams the 512-bit result {1'b0, x, 1'b0, y} out as DATA_W-bit words over a valid/ready handshake, most-significant word first.
- Final stage before the top-level output port.

Parameters:
- DATA_W, 64, output word width; must divide 256 (legal: 8, 16, 32, 64, 128, 256).
- N_WORDS, 512/DATA_W, derived localparam, not overridable.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_start  input  1  one-cycle pulse; i_x/i_y valid this cycle (driven from upstream o_finished)
- i_x  input  255  affine x from reduction stage
- i_y  input  255  affine y from reduction stage
- o_data  output  DATA_W  current output word
- o_valid  output  1  o_data valid
- i_ready  input  1  sink accepts o_data when o_valid & i_ready
- o_busy  output  1  high from capture until last word accepted
- o_done  output  1  one-cycle pulse after last word accepted
- o_drop  output  1  one-cycle pulse: i_start arrived while busy and was discarded

Behaviour:
- Reset, synchronous on i_rst=1:
  - all outputs 0; state S_IDLE; word counter 0; x/y registers 0.
  - Reset during S_CANON or S_SEND aborts immediately; no o_done; any partially sent point is lost.
- States: S_IDLE, S_CANON, S_SEND.
- S_IDLE:
  - on i_start, register i_x, i_y; go to S_CANON; o_busy=1 from next cycle.
- S_CANON (exactly 1 cycle):
  - each register <= (v >= p) ? v - p : v, via one compare-subtract.
  - Inputs are 255 bits, so v < 2p always; one subtraction suffices.
  - Counter k <= 0; go to S_SEND.
- S_SEND:
  - o_valid=1; o_data = packed[511 - k*DATA_W -: DATA_W], packed = {1'b0, x_c, 1'b0, y_c}.
  - Lane bits 511 and 255 are always 0.
  - On o_valid & i_ready: if k == N_WORDS-1, go to S_IDLE with o_done=1, o_busy=0, o_valid=0 next cycle; else k <= k+1.
  - With o_valid=1 and i_ready=0, o_data and k hold stable. o_valid never drops before acceptance.
- Outputs are registered:
  - o_valid/o_data change only on clock edges.
  - o_data is 0 whenever o_valid=0.
- Latency: i_start at cycle 0 gives first o_valid at cycle 2. With i_ready tied high, the last word is at cycle N_WORDS+1 and o_done at cycle N_WORDS+2.
- A new i_start is accepted in the same cycle o_done is high (state already S_IDLE).
- Busy-start rule:
  - i_start while in S_CANON or S_SEND (including the cycle the last word is accepted) is ignored.
  - Captured data unchanged; o_drop=1 next cycle.
- Simultaneous i_rst and i_start: reset wins; nothing captured.
- i_ready is ignored outside S_SEND.

Decomposition:
- Package point_io_pkg:
  - localparam P (255-bit, 2^255-19)
  - state_t enum (S_IDLE, S_CANON, S_SEND), 2-bit
  - LANE_W = 256
- Sub-module fe_canon: combinational 255-bit compare-and-subtract of P (i_v, o_v), instantiated twice (x, y).
- Counter width $clog2(N_WORDS), minimum 1.

Test Plan:
- x=1, y=2, i_ready=1, DATA_W=64 -> 8 words 0,0,0,1,0,0,0,2 on cycles 2..9; o_done at cycle 10; o_busy high cycles 1..9.
- x=p, y=p+5 (non-canonical) -> x lane all zero; y words 0,0,0,5.
- x = y = 2^255-20 (p-1), i_ready toggling 1,0,0,1,... -> words x: 7FFF...FFFF, FFFF...FFFF, FFFF...FFFF, FFFF...FFEC then same for y. Each word is held stable through i_ready=0 cycles. Exactly 8 handshakes.
- i_start pulses at cycles 0 and 4 (x=1 then x=9) -> second dropped; o_drop=1 at cycle 5; output stream still carries x=1.
- i_rst=1 at cycle 5 mid-send -> o_valid, o_busy, o_data = 0 at cycle 6; no o_done. A fresh i_start at cycle 7 produces a complete correct stream.
- DATA_W=32, x=0x1234, y=0 -> 16 words; word 7 = 0x00001234, all others 0. i_start coincident with o_done of the previous point is accepted (no o_drop).

Source files
------------

// File: rtl/point_io_pkg.sv
// Shared definitions for the point output path: field prime, lane width, FSM states.
package point_io_pkg;

  localparam int unsigned FE_W   = 255;
  localparam int unsigned LANE_W = 256;

  // p = 2^255 - 19
  localparam logic [FE_W-1:0] P = {{247{1'b1}}, 8'hED};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CANON = 2'd1,
    S_SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/fe_canon.sv
// Combinational canonicalisation of a 255-bit field element into [0, p).
// Ports: i_v - raw value (always < 2p), o_v - canonical value.
module fe_canon
  import point_io_pkg::*;
(
  input  logic [FE_W-1:0] i_v,
  output logic [FE_W-1:0] o_v
);

  // A 255-bit input is below 2p, so a single conditional subtract is enough.
  always_comb begin
    o_v = (i_v >= P) ? (i_v - P) : i_v;
  end

endmodule

// File: rtl/point_out_serializer.sv
// Captures an affine point (x, y), canonicalises both coordinates and streams
// {1'b0, x, 1'b0, y} out most-significant word first over valid/ready.
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_start, i_x, i_y   - one-cycle capture pulse with point coordinates
//   o_data, o_valid     - output word and its valid, held until i_ready
//   i_ready             - sink acceptance
//   o_busy              - capture through last-word acceptance
//   o_done              - pulse after the last word is accepted
//   o_drop              - pulse when i_start arrived while busy
module point_out_serializer
  import point_io_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [FE_W-1:0]   i_x,
  input  logic [FE_W-1:0]   i_y,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_drop
);

  localparam int unsigned PACK_W  = 2 * LANE_W;
  localparam int unsigned N_WORDS = PACK_W / DATA_W;
  localparam int unsigned K_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_WORDS - 1);

  state_t              state;
  logic [FE_W-1:0]     x_r;
  logic [FE_W-1:0]     y_r;
  logic [FE_W-1:0]     x_c;
  logic [FE_W-1:0]     y_c;
  logic [K_W-1:0]      k;
  logic [K_W-1:0]      k_nxt_c;
  logic [PACK_W-1:0]   pack_canon_c;
  logic [PACK_W-1:0]   pack_reg_c;

  fe_canon u_canon_x (.i_v(x_r), .o_v(x_c));
  fe_canon u_canon_y (.i_v(y_r), .o_v(y_c));

  assign pack_canon_c = {1'b0, x_c, 1'b0, y_c};
  assign pack_reg_c   = {1'b0, x_r, 1'b0, y_r};
  assign k_nxt_c      = k + K_W'(1);

  // Word idx counted from the MSB end of the packed vector.
  function automatic logic [DATA_W-1:0] word_sel(input logic [PACK_W-1:0] pk,
                                                 input logic [K_W-1:0]    idx);
    word_sel = DATA_W'(pk >> ((N_WORDS - 1 - 32'(idx)) * DATA_W));
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      x_r     <= '0;
      y_r     <= '0;
      k       <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_drop <= 1'b0;

      // A start outside idle is discarded; captured data is untouched.
      if (i_start && (state != S_IDLE)) begin
        o_drop <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (i_start) begin
            x_r    <= i_x;
            y_r    <= i_y;
            o_busy <= 1'b1;
            state  <= S_CANON;
          end
        end
        S_CANON: begin
          // First word comes straight from the canonical values so it lands
          // together with the register update.
          x_r     <= x_c;
          y_r     <= y_c;
          k       <= '0;
          o_valid <= 1'b1;
          o_data  <= word_sel(pack_canon_c, K_W'(0));
          state   <= S_SEND;
        end
        S_SEND: begin
          if (i_ready) begin
            if (k == K_LAST) begin
              o_valid <= 1'b0;
              o_data  <= '0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              state   <= S_IDLE;
            end else begin
              k      <= k_nxt_c;
              o_data <= word_sel(pack_reg_c, k_nxt_c);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_out_serializer.sv
// Table-driven plus hand-sequenced bench with a word scoreboard for
// point_out_serializer (DATA_W=64 main instance, DATA_W=32 second instance).
module tb_point_out_serializer;

  localparam logic [254:0] PRIME = {{247{1'b1}}, 8'hED};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, ready;
  logic [254:0] x, y;
  logic [63:0]  data;
  logic         valid, busy, done, drop;

  logic         start2, ready2;
  logic [254:0] x2, y2;
  logic [31:0]  data2;
  logic         valid2, busy2, done2, drop2;

  point_out_serializer #(.DATA_W(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_x(x), .i_y(y),
    .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_busy(busy), .o_done(done), .o_drop(drop)
  );

  point_out_serializer #(.DATA_W(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_x(x2), .i_y(y2),
    .o_data(data2), .o_valid(valid2), .i_ready(ready2),
    .o_busy(busy2), .o_done(done2), .o_drop(drop2)
  );

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;

  logic [63:0] sbq[$];
  logic [31:0] sbq2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [511:0] e);
    for (int i = 0; i < 8; i++) sbq.push_back(e[511 - 64*i -: 64]);
  endtask

  task automatic push_exp2(input logic [511:0] e);
    for (int i = 0; i < 16; i++) sbq2.push_back(e[511 - 32*i -: 32]);
  endtask

  // Scoreboard and protocol monitor for the 64-bit instance.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid === 1'b0) check("idle_data_zero", data, 64'd0);
      if (prev_stall) begin
        check("stall_valid_hold", 64'(valid), 64'd1);
        check("stall_data_hold", data, prev_data);
      end
      if (done === 1'b1) done_cnt++;
      if (valid === 1'b1 && ready === 1'b1) begin
        hs_cnt++;
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_word: got %h expected no word", data);
        end else begin
          check("word", data, sbq.pop_front());
        end
      end
      prev_stall = (valid === 1'b1) && (ready === 1'b0) && (rst === 1'b0);
      prev_data  = data;
    end
  end

  // Scoreboard for the 32-bit instance.
  always @(negedge clk) begin
    if (mon_en && valid2 === 1'b1 && ready2 === 1'b1) begin
      if (sbq2.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_word32: got %h expected no word", data2);
      end else begin
        check("word32", 64'(data2), 64'(sbq2.pop_front()));
      end
    end
  end

  // Drive i_ready (optionally 1,0,0 repeating) until o_done or budget expires.
  task automatic run_until_done(input bit toggle, input int budget);
    int  c = 0;
    bit  seen = 1'b0;
    while (!seen && c < budget) begin
      ready = toggle ? ((c % 3) == 0) : 1'b1;
      @(posedge clk); #1;
      c++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    ready = 1'b1;
  endtask

  task automatic pulse_start(input logic [254:0] xv, input logic [254:0] yv);
    x = xv; y = yv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic [254:0] x;
    logic [254:0] y;
    logic [511:0] e;
    bit           tog;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int           hs0, dc0;
    logic [511:0] e2;
    bit           seen;
    int           c;

    tbl[0] = '{x: 255'd1, y: 255'd2, e: {256'd1, 256'd2}, tog: 1'b0};
    tbl[1] = '{x: PRIME, y: PRIME + 255'd5, e: {256'd0, 256'd5}, tog: 1'b0};
    tbl[2] = '{x: PRIME - 255'd1, y: PRIME - 255'd1,
               e: {8'h7F, {30{8'hFF}}, 8'hEC, 8'h7F, {30{8'hFF}}, 8'hEC}, tog: 1'b1};
    tbl[3] = '{x: {255{1'b1}}, y: {1'b1, 254'd0},
               e: {256'd18, 8'h40, 248'd0}, tog: 1'b0};

    rst = 1'b1; start = 1'b0; ready = 1'b1; x = '0; y = '0;
    start2 = 1'b0; ready2 = 1'b1; x2 = '0; y2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Reset state.
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_data", data, 64'd0);

    // Cycle-exact latency for x=1, y=2 with i_ready high.
    push_exp({256'd1, 256'd2});
    x = 255'd1; y = 255'd2; start = 1'b1;
    check("lat_busy_c0", 64'(busy), 64'd0);
    for (int cy = 1; cy <= 11; cy++) begin
      @(posedge clk); #1;
      if (cy == 1) start = 1'b0;
      check($sformatf("lat_busy_c%0d", cy), 64'(busy), 64'((cy >= 1 && cy <= 9)));
      check($sformatf("lat_valid_c%0d", cy), 64'(valid), 64'((cy >= 2 && cy <= 9)));
      check($sformatf("lat_done_c%0d", cy), 64'(done), 64'(cy == 10));
    end
    check("lat_queue_empty", 64'(sbq.size()), 64'd0);

    // Table vectors.
    foreach (tbl[i]) begin
      hs0 = hs_cnt;
      push_exp(tbl[i].e);
      pulse_start(tbl[i].x, tbl[i].y);
      run_until_done(tbl[i].tog, 80);
      check($sformatf("tbl%0d_handshakes", i), 64'(hs_cnt - hs0), 64'd8);
      check($sformatf("tbl%0d_queue_empty", i), 64'(sbq.size()), 64'd0);
      @(posedge clk); #1;
    end

    // Busy start is dropped; stream still carries the first point.
    push_exp({256'd1, 256'd0});
    x = 255'd1; y = 255'd0; start = 1'b1;
    for (int cy = 1; cy <= 5; cy++) begin
      @(posedge clk); #1;
      if (cy == 1) start = 1'b0;
      if (cy == 4) begin
        check("drop_c4", 64'(drop), 64'd0);
        x = 255'd9; start = 1'b1;
      end
      if (cy == 5) begin
        start = 1'b0;
        check("drop_c5", 64'(drop), 64'd1);
      end
    end
    run_until_done(1'b0, 40);
    check("drop_queue_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;

    // Reset mid-send aborts; fresh start afterwards streams fully.
    push_exp({256'd3, 256'd4});
    x = 255'd3; y = 255'd4; start = 1'b1;
    for (int cy = 1; cy <= 6; cy++) begin
      @(posedge clk); #1;
      if (cy == 1) start = 1'b0;
      if (cy == 5) begin
        dc0 = done_cnt;
        rst = 1'b1;
      end
      if (cy == 6) begin
        rst = 1'b0;
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_data", data, 64'd0);
        sbq.delete();
      end
    end
    repeat (4) @(posedge clk);
    #1 check("abort_no_done", 64'(done_cnt - dc0), 64'd0);
    push_exp({256'd5, 256'd6});
    pulse_start(255'd5, 255'd6);
    run_until_done(1'b0, 40);
    check("abort_queue_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;

    // Simultaneous reset and start: nothing captured.
    rst = 1'b1; x = 255'd7; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 check("rst_start_valid", 64'(valid), 64'd0);

    // 32-bit instance: 16 words, then a start coincident with o_done.
    e2 = {256'h1234, 256'd0};
    push_exp2(e2);
    x2 = 255'h1234; y2 = '0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    c = 0; seen = 1'b0;
    while (!seen && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (done2) seen = 1'b1;
    end
    check("w32_done_seen", 64'(seen), 64'd1);
    check("w32_latency", 64'(c), 64'd17);
    push_exp2(e2);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("w32_coincident_no_drop", 64'(drop2), 64'd0);
    check("w32_coincident_busy", 64'(busy2), 64'd1);
    c = 0; seen = 1'b0;
    while (!seen && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (done2) seen = 1'b1;
    end
    check("w32_done2_seen", 64'(seen), 64'd1);
    check("w32_queue_empty", 64'(sbq2.size()), 64'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
